// File: rtl/slb.sv
// -----------------------------------------------------------------------------
// slb - store/load buffer for the Tomasulo core.
//
// Holds every load and store in dispatch order. Each entry watches the result
// broadcasts (EX unit and the buffer's own load results) for its missing
// operands. Only the head entry may talk to the memory controller: loads go
// as soon as their base is known, and stores wait until the ROB commits them.
// A finished entry is popped and announced with a one-cycle result pulse.
//
// Op encoding (iDP_op): bit 3 = store, bit 2 = unsigned load, bits 1:0 = size
//   LB=4'h0 LH=4'h1 LW=4'h2 LBU=4'h4 LHU=4'h5 SB=4'h8 SH=4'h9 SW=4'hA
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global enable (low = hold, a pending iMC_done is kept)
//   iclr                mispredict flush
//   oSLB_full           queue full (combinational)
//   iDP_*               dispatch: op, nick, vj/vk values, qj/qk tags, imm
//   iEX_en/nick/dt      EX result broadcast
//   iROB_store_en/nick  store commit from ROB head
//   oSLB_en/nick/dt     result pulse (load data, or 0 for a finished store)
//   oMC_*               memory request, held until iMC_done
//   iMC_done, iMC_dt    memory completion pulse and read data
// -----------------------------------------------------------------------------
module slb #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int NICK_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    output logic              oSLB_full,
    input  logic              iDP_en,
    input  logic [3:0]        iDP_op,
    input  logic [NICK_W-1:0] iDP_nick,
    input  logic [31:0]       iDP_vj,
    input  logic [31:0]       iDP_vk,
    input  logic [NICK_W-1:0] iDP_qj,
    input  logic [NICK_W-1:0] iDP_qk,
    input  logic [31:0]       iDP_imm,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [31:0]       iEX_dt,
    input  logic              iROB_store_en,
    input  logic [NICK_W-1:0] iROB_store_nick,
    output logic              oSLB_en,
    output logic [NICK_W-1:0] oSLB_nick,
    output logic [31:0]       oSLB_dt,
    output logic              oMC_en,
    output logic              oMC_wr,
    output logic [31:0]       oMC_addr,
    output logic [1:0]        oMC_len,
    output logic [31:0]       oMC_dt,
    input  logic              iMC_done,
    input  logic [31:0]       iMC_dt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    // Entry storage is kept in flops: every entry is snooped every cycle.
    logic [3:0]        op_reg    [DEPTH];
    logic [NICK_W-1:0] nick_reg  [DEPTH];
    logic [31:0]       vj_reg    [DEPTH];
    logic [NICK_W-1:0] qj_reg    [DEPTH];
    logic [31:0]       vk_reg    [DEPTH];
    logic [NICK_W-1:0] qk_reg    [DEPTH];
    logic [31:0]       imm_reg   [DEPTH];
    logic [DEPTH-1:0]  committed_reg;
    logic [DEPTH-1:0]  valid_reg;

    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [PTR_W:0]    count_reg;
    state_t            state_reg, state_next;
    logic              done_pend_reg;
    logic [31:0]       pend_dt_reg;
    logic              load_res_reg;

    logic              push, pop, issue, finish, mc_release, done_seen, own_en;
    logic              can_issue;
    logic [31:0]       done_data, ext_data;

    logic [3:0]        h_op;
    logic [NICK_W-1:0] h_nick;

    assign oSLB_full = (count_reg == (PTR_W+1)'(DEPTH));
    assign push      = rdy && iDP_en && !oSLB_full && !iclr;
    assign pop       = finish;
    assign own_en    = oSLB_en && load_res_reg;

    // A completion seen while rdy was low is remembered until it can be acted on.
    assign done_seen = iMC_done || done_pend_reg;
    assign done_data = done_pend_reg ? pend_dt_reg : iMC_dt;

    assign h_op   = op_reg[head_reg];
    assign h_nick = nick_reg[head_reg];

    assign can_issue = (count_reg != '0) && (qj_reg[head_reg] == '0) &&
                       (!h_op[3] || ((qk_reg[head_reg] == '0) && committed_reg[head_reg]));

    // Broadcast match for a pending tag; tag 0 means "value already present".
    function automatic logic bc_hit(input logic [NICK_W-1:0] tag);
        return (tag != '0) && ((iEX_en && (iEX_nick == tag)) ||
                               (own_en && (oSLB_nick == tag)));
    endfunction

    function automatic logic [31:0] bc_data(input logic [NICK_W-1:0] tag);
        return (iEX_en && (iEX_nick == tag)) ? iEX_dt : oSLB_dt;
    endfunction

    // Load data extension by size and signedness of the head op.
    always_comb begin
        ext_data = done_data;
        case (h_op[1:0])
            2'd0:    ext_data = h_op[2] ? {24'd0, done_data[7:0]}
                                        : {{24{done_data[7]}}, done_data[7:0]};
            2'd1:    ext_data = h_op[2] ? {16'd0, done_data[15:0]}
                                        : {{16{done_data[15]}}, done_data[15:0]};
            default: ext_data = done_data;
        endcase
    end

    // FSM next state
    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        finish     = 1'b0;
        mc_release = 1'b0;
        if (rdy) begin
            case (state_reg)
                S_IDLE: begin
                    if (!iclr && can_issue) begin
                        issue      = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_seen) begin
                        // A flush in the done cycle suppresses the result.
                        mc_release = 1'b1;
                        finish     = !iclr;
                        state_next = S_IDLE;
                    end else if (iclr) begin
                        state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done_seen) begin
                        mc_release = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Queue pointers and pending-completion latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            done_pend_reg <= 1'b0;
            pend_dt_reg   <= '0;
        end else begin
            if (mc_release) begin
                done_pend_reg <= 1'b0;
            end else if (iMC_done && (state_reg != S_IDLE) && !done_pend_reg) begin
                done_pend_reg <= 1'b1;
                pend_dt_reg   <= iMC_dt;
            end
            if (rdy) begin
                if (iclr) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    tail_reg  <= tail_reg + PTR_W'(push);
                    head_reg  <= head_reg + PTR_W'(pop);
                    count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
                end
            end
        end
    end

    // Entry array: dispatch write, operand snoop, commit marking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= '0;
            committed_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_reg[i]   <= '0;
                nick_reg[i] <= '0;
                vj_reg[i]   <= '0;
                qj_reg[i]   <= '0;
                vk_reg[i]   <= '0;
                qk_reg[i]   <= '0;
                imm_reg[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (iclr) begin
                    valid_reg[i] <= 1'b0;
                end else if (push && (tail_reg == PTR_W'(i))) begin
                    valid_reg[i]     <= 1'b1;
                    committed_reg[i] <= 1'b0;
                    op_reg[i]        <= iDP_op;
                    nick_reg[i]      <= iDP_nick;
                    imm_reg[i]       <= iDP_imm;
                    vj_reg[i]        <= bc_hit(iDP_qj) ? bc_data(iDP_qj) : iDP_vj;
                    qj_reg[i]        <= bc_hit(iDP_qj) ? '0 : iDP_qj;
                    vk_reg[i]        <= bc_hit(iDP_qk) ? bc_data(iDP_qk) : iDP_vk;
                    qk_reg[i]        <= bc_hit(iDP_qk) ? '0 : iDP_qk;
                end else if (valid_reg[i]) begin
                    if (pop && (head_reg == PTR_W'(i)))
                        valid_reg[i] <= 1'b0;
                    if (bc_hit(qj_reg[i])) begin
                        vj_reg[i] <= bc_data(qj_reg[i]);
                        qj_reg[i] <= '0;
                    end
                    if (bc_hit(qk_reg[i])) begin
                        vk_reg[i] <= bc_data(qk_reg[i]);
                        qk_reg[i] <= '0;
                    end
                    if (iROB_store_en && (nick_reg[i] == iROB_store_nick))
                        committed_reg[i] <= 1'b1;
                end
            end
        end
    end

    // Memory request and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oSLB_en      <= 1'b0;
            oSLB_nick    <= '0;
            oSLB_dt      <= '0;
            load_res_reg <= 1'b0;
            oMC_en       <= 1'b0;
            oMC_wr       <= 1'b0;
            oMC_addr     <= '0;
            oMC_len      <= '0;
            oMC_dt       <= '0;
        end else begin
            oSLB_en <= finish;
            if (finish) begin
                oSLB_nick    <= h_nick;
                oSLB_dt      <= h_op[3] ? 32'd0 : ext_data;
                load_res_reg <= !h_op[3];
            end
            if (issue) begin
                oMC_en   <= 1'b1;
                oMC_wr   <= h_op[3];
                oMC_addr <= vj_reg[head_reg] + imm_reg[head_reg];
                oMC_len  <= h_op[1:0];
                oMC_dt   <= vk_reg[head_reg];
            end else if (mc_release) begin
                oMC_en   <= 1'b0;
                oMC_wr   <= 1'b0;
                oMC_addr <= '0;
                oMC_len  <= '0;
                oMC_dt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_slb.sv
// -----------------------------------------------------------------------------
// tb_slb - scoreboard bench for slb. Expected memory requests and results are
// queued when stimulus is driven; a memory responder and a result monitor pop
// and compare them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_slb;

    localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4, LHU = 4'h5;
    localparam logic [3:0] SB = 4'h8, SW = 4'hA;

    logic        clk = 1'b0;
    logic        rst, rdy, iclr;
    logic        oSLB_full;
    logic        iDP_en;
    logic [3:0]  iDP_op;
    logic [4:0]  iDP_nick, iDP_qj, iDP_qk;
    logic [31:0] iDP_vj, iDP_vk, iDP_imm;
    logic        iEX_en;
    logic [4:0]  iEX_nick;
    logic [31:0] iEX_dt;
    logic        iROB_store_en;
    logic [4:0]  iROB_store_nick;
    logic        oSLB_en;
    logic [4:0]  oSLB_nick;
    logic [31:0] oSLB_dt;
    logic        oMC_en, oMC_wr;
    logic [31:0] oMC_addr, oMC_dt;
    logic [1:0]  oMC_len;
    logic        iMC_done;
    logic [31:0] iMC_dt;

    slb dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr), .oSLB_full(oSLB_full),
        .iDP_en(iDP_en), .iDP_op(iDP_op), .iDP_nick(iDP_nick),
        .iDP_vj(iDP_vj), .iDP_vk(iDP_vk), .iDP_qj(iDP_qj), .iDP_qk(iDP_qk),
        .iDP_imm(iDP_imm),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
        .iROB_store_en(iROB_store_en), .iROB_store_nick(iROB_store_nick),
        .oSLB_en(oSLB_en), .oSLB_nick(oSLB_nick), .oSLB_dt(oSLB_dt),
        .oMC_en(oMC_en), .oMC_wr(oMC_wr), .oMC_addr(oMC_addr),
        .oMC_len(oMC_len), .oMC_dt(oMC_dt),
        .iMC_done(iMC_done), .iMC_dt(iMC_dt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] dt;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic [4:0]  nick;
        logic [31:0] dt;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc = 0;
    int credits  = 1000000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [4:0] nick,
                            input logic [31:0] vj, input logic [4:0] qj,
                            input logic [31:0] vk, input logic [4:0] qk,
                            input logic [31:0] imm);
        iDP_op = op; iDP_nick = nick; iDP_vj = vj; iDP_qj = qj;
        iDP_vk = vk; iDP_qk = qk; iDP_imm = imm; iDP_en = 1'b1;
        step(1);
        iDP_en = 1'b0;
    endtask

    // Ready load with its expected request and result queued.
    task automatic ld(input logic [3:0] op, input logic [4:0] nick, input logic [31:0] base,
                      input logic [31:0] imm, input logic [31:0] rdata, input logic [31:0] res);
        exp_req.push_back('{1'b0, base + imm, op[1:0], 32'd0, rdata});
        exp_res.push_back('{nick, res});
        dispatch(op, nick, base, 5'd0, 32'd0, 5'd0, imm);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_req.size() == 0 && exp_res.size() == 0) break;
            step(1);
        end
        check_val("drain", 32'(exp_req.size() + exp_res.size()), 32'd0);
    endtask

    // Memory controller model: checks each request, then completes it when a credit exists.
    initial begin
        req_t r;
        int   n;
        iMC_done = 1'b0;
        iMC_dt   = '0;
        r = '{1'b0, 32'd0, 2'd0, 32'd0, 32'd0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst && oMC_en) begin
                check_val("req_pending", 32'(exp_req.size() > 0), 32'd1);
                if (exp_req.size() > 0) begin
                    r = exp_req.pop_front();
                    $display("REQ wr=%0b addr=%h len=%0d dt=%h", oMC_wr, oMC_addr, oMC_len, oMC_dt);
                    check_val("req_wr", 32'(oMC_wr), 32'(r.wr));
                    check_val("req_addr", oMC_addr, r.addr);
                    check_val("req_len", 32'(oMC_len), 32'(r.len));
                    check_val("req_dt", oMC_dt, r.dt);
                end
                n = 0;
                while (credits == 0 && n < 3000) begin
                    step(1);
                    n++;
                end
                if (credits == 0) check_val("mem_credit_timeout", 32'(n), 32'd0);
                else credits--;
                step(1);
                iMC_done = 1'b1;
                iMC_dt   = r.rdata;
                done_cyc = cyc;
                step(1);
                iMC_done = 1'b0;
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        res_t e;
        if (!rst && oSLB_en) begin
            $display("RES nick=%0d dt=%h", oSLB_nick, oSLB_dt);
            check_val("res_pending", 32'(exp_res.size() > 0), 32'd1);
            if (exp_res.size() > 0) begin
                e = exp_res.pop_front();
                check_val("res_nick", 32'(oSLB_nick), 32'(e.nick));
                check_val("res_dt", oSLB_dt, e.dt);
                check_val("res_latency", 32'(cyc - done_cyc), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; iclr = 1'b0;
        iDP_en = 1'b0; iDP_op = '0; iDP_nick = '0; iDP_vj = '0; iDP_vk = '0;
        iDP_qj = '0; iDP_qk = '0; iDP_imm = '0;
        iEX_en = 1'b0; iEX_nick = '0; iEX_dt = '0;
        iROB_store_en = 1'b0; iROB_store_nick = '0;
        step(3);
        @(negedge clk);
        check_val("rst_mc_en", 32'(oMC_en), 32'd0);
        check_val("rst_slb_en", 32'(oSLB_en), 32'd0);
        check_val("rst_full", 32'(oSLB_full), 32'd0);
        check_val("rst_addr", oMC_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // Basic word load
        ld(LW, 5'd1, 32'h100, 32'd4, 32'hDEADBEEF, 32'hDEADBEEF);
        wait_drain(200);

        // Size and sign handling; upper bytes of read data are not valid
        ld(LB,  5'd2, 32'h200, 32'd1, 32'hABCDEF80, 32'hFFFFFF80);
        ld(LBU, 5'd3, 32'h200, 32'd1, 32'hABCDEF80, 32'h00000080);
        ld(LH,  5'd4, 32'h200, 32'd2, 32'hABCD8001, 32'hFFFF8001);
        ld(LHU, 5'd5, 32'h200, 32'd2, 32'h12348001, 32'h00008001);
        ld(LB,  5'd6, 32'h200, 32'd3, 32'hFFFFFF7F, 32'h0000007F);
        wait_drain(300);

        // Store waits for commit
        dispatch(SW, 5'd7, 32'h300, 5'd0, 32'hCAFEF00D, 5'd0, 32'd0);
        step(20);
        check_val("sw_uncommitted", 32'(oMC_en), 32'd0);
        exp_req.push_back('{1'b1, 32'h300, 2'd2, 32'hCAFEF00D, 32'd0});
        exp_res.push_back('{5'd7, 32'd0});
        iROB_store_en = 1'b1; iROB_store_nick = 5'd7;
        step(1);
        iROB_store_en = 1'b0;
        wait_drain(200);

        // Commit for a different nick leaves the store parked
        dispatch(SB, 5'd12, 32'h310, 5'd0, 32'h00000055, 5'd0, 32'd1);
        iROB_store_en = 1'b1; iROB_store_nick = 5'd13;
        step(1);
        iROB_store_en = 1'b0;
        step(5);
        check_val("sb_wrong_commit", 32'(oMC_en), 32'd0);
        exp_req.push_back('{1'b1, 32'h311, 2'd0, 32'h00000055, 32'd0});
        exp_res.push_back('{5'd12, 32'd0});
        iROB_store_en = 1'b1; iROB_store_nick = 5'd12;
        step(1);
        iROB_store_en = 1'b0;
        wait_drain(200);

        // Operand wait on an EX tag
        dispatch(LW, 5'd8, 32'd0, 5'd5, 32'd0, 5'd0, 32'h10);
        step(5);
        check_val("load_wait_qj", 32'(oMC_en), 32'd0);
        exp_req.push_back('{1'b0, 32'h210, 2'd2, 32'd0, 32'h11111111});
        exp_res.push_back('{5'd8, 32'h11111111});
        iEX_en = 1'b1; iEX_nick = 5'd5; iEX_dt = 32'h200;
        step(1);
        iEX_en = 1'b0;
        wait_drain(200);

        // Broadcast in the dispatch cycle is captured
        exp_req.push_back('{1'b0, 32'h408, 2'd2, 32'd0, 32'h22222222});
        exp_res.push_back('{5'd9, 32'h22222222});
        iEX_en = 1'b1; iEX_nick = 5'd6; iEX_dt = 32'h400;
        dispatch(LW, 5'd9, 32'hBAD0BAD0, 5'd6, 32'd0, 5'd0, 32'd8);
        iEX_en = 1'b0;
        wait_drain(200);

        // Dependent load fed by the buffer's own load result
        ld(LW, 5'd10, 32'h500, 32'd0, 32'h00000600, 32'h00000600);
        exp_req.push_back('{1'b0, 32'h604, 2'd2, 32'd0, 32'h33333333});
        exp_res.push_back('{5'd11, 32'h33333333});
        dispatch(LW, 5'd11, 32'd0, 5'd10, 32'd0, 5'd0, 32'd4);
        wait_drain(300);

        // Fill all entries, drop the overflow, pop one, refill across the wrap
        credits = 0;
        for (int i = 0; i < 16; i++)
            ld(LW, 5'(i + 1), 32'h1000, 32'(4 * i), 32'h10000000 + 32'(i), 32'h10000000 + 32'(i));
        @(negedge clk);
        check_val("full_after_16", 32'(oSLB_full), 32'd1);
        step(1);
        dispatch(LW, 5'd17, 32'h0BAD, 5'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk);
        check_val("full_after_drop", 32'(oSLB_full), 32'd1);
        step(1);
        credits = 1;
        for (int i = 0; i < 200; i++) begin
            if (exp_res.size() == 15) break;
            step(1);
        end
        check_val("first_pop", 32'(exp_res.size()), 32'd15);
        @(negedge clk);
        check_val("not_full_after_pop", 32'(oSLB_full), 32'd0);
        step(1);
        ld(LW, 5'd30, 32'h2000, 32'd0, 32'h2000AAAA, 32'h2000AAAA);
        @(negedge clk);
        check_val("full_after_wrap", 32'(oSLB_full), 32'd1);
        step(1);
        credits = 1000000;
        wait_drain(1000);

        // Flush while a load is outstanding
        credits = 0;
        exp_req.push_back('{1'b0, 32'h700, 2'd2, 32'd0, 32'h44444444});
        dispatch(LW, 5'd20, 32'h700, 5'd0, 32'd0, 5'd0, 32'd0);
        dispatch(LW, 5'd21, 32'h704, 5'd0, 32'd0, 5'd0, 32'd0);
        step(3);
        iclr = 1'b1;
        step(1);
        iclr = 1'b0;
        @(negedge clk);
        check_val("clr_mc_held", 32'(oMC_en), 32'd1);
        check_val("clr_not_full", 32'(oSLB_full), 32'd0);
        step(1);
        credits = 1;
        step(8);
        check_val("clr_mc_released", 32'(oMC_en), 32'd0);
        credits = 1000000;
        ld(LHU, 5'd22, 32'h720, 32'd2, 32'h0000FFFE, 32'h0000FFFE);
        wait_drain(200);

        // Asynchronous reset in the middle of a request
        credits = 0;
        exp_req.push_back('{1'b0, 32'h800, 2'd2, 32'd0, 32'h55555555});
        dispatch(LW, 5'd23, 32'h800, 5'd0, 32'd0, 5'd0, 32'd0);
        step(4);
        check_val("pre_rst_mc_en", 32'(oMC_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_mc_en", 32'(oMC_en), 32'd0);
        check_val("arst_mc_addr", oMC_addr, 32'd0);
        check_val("arst_slb_en", 32'(oSLB_en), 32'd0);
        check_val("arst_full", 32'(oSLB_full), 32'd0);
        credits = 1;
        step(6);
        rst = 1'b0;
        step(4);
        check_val("post_rst_idle", 32'(oMC_en), 32'd0);
        wait_drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
